// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch PC controller: BTB branch-type encodings
// and the RUN/MISS state of the fetch FSM.
package fetch_pc_ctrl_pkg;

  localparam logic [1:0] BT_RET  = 2'b00;
  localparam logic [1:0] BT_CALL = 2'b01;
  localparam logic [1:0] BT_JUMP = 2'b10;
  localparam logic [1:0] BT_COND = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MISS = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_lane_sel.sv
// Purely combinational lane selector: finds the lowest taken lane, builds the
// valid-lane mask and returns that lane's BTB target and branch type.
module fetch_lane_sel
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int PC_W        = 32,
  parameter int TK_W        = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic [FETCH_WIDTH-1:0]      btb_hit,
  input  logic [2*FETCH_WIDTH-1:0]    btb_type,
  input  logic [PC_W*FETCH_WIDTH-1:0] btb_target,
  input  logic [FETCH_WIDTH-1:0]      pred,
  output logic                        any_taken,
  output logic [TK_W-1:0]             tk,
  output logic [FETCH_WIDTH-1:0]      lane_mask,
  output logic [PC_W-1:0]             sel_target,
  output logic [1:0]                  sel_type
);

  logic [FETCH_WIDTH-1:0] taken;
  logic                   found;

  // NOTE: every signal gets a default before the loop so no latch is inferred.
  always_comb begin
    taken      = '0;
    lane_mask  = '0;
    found      = 1'b0;
    tk         = '0;
    sel_target = '0;
    sel_type   = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      taken[k]     = btb_hit[k] & ((btb_type[2*k +: 2] != BT_COND) | pred[k]);
      // A lane is valid until a lower lane has already redirected the fetch.
      lane_mask[k] = ~found;
      if (taken[k] && !found) begin
        found      = 1'b1;
        tk         = TK_W'(k);
        sel_target = btb_target[PC_W*k +: PC_W];
        sel_type   = btb_type[2*k +: 2];
      end
    end
    any_taken = found;
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller with redirect priority, BTB-based prediction and an
// I-cache miss FSM. Define FETCH_RAS_EN to enable return-address-stack usage.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int              FETCH_WIDTH = 4,
  parameter int              INST_BYTES  = 8,
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall_i,
  input  logic                        recover_valid_i,
  input  logic [PC_W-1:0]             recover_pc_i,
  input  logic                        exc_valid_i,
  input  logic [PC_W-1:0]             exc_pc_i,
  input  logic                        redir_ex_i,
  input  logic [PC_W-1:0]             redir_ex_pc_i,
  input  logic                        redir_id_i,
  input  logic [PC_W-1:0]             redir_id_pc_i,
  input  logic [FETCH_WIDTH-1:0]      btb_hit_i,
  input  logic [2*FETCH_WIDTH-1:0]    btb_type_i,
  input  logic [PC_W*FETCH_WIDTH-1:0] btb_target_i,
  input  logic [FETCH_WIDTH-1:0]      pred_i,
  input  logic [PC_W-1:0]             ras_top_i,
  input  logic                        icache_miss_i,
  input  logic                        refill_done_i,
  output logic [PC_W-1:0]             pc_o,
  output logic                        valid_o,
  output logic [FETCH_WIDTH-1:0]      lane_mask_o,
  output logic                        ras_push_o,
  output logic [PC_W-1:0]             ras_push_addr_o,
  output logic                        ras_pop_o,
  output logic                        miss_o,
  output logic [PC_W-1:0]             miss_addr_o
);

  localparam int              TK_W   = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam logic [PC_W-1:0] STRIDE = PC_W'(FETCH_WIDTH * INST_BYTES);

  fetch_state_e    state, next_state;
  logic [PC_W-1:0] pc, next_pc;
  logic            any_taken;
  logic [TK_W-1:0] tk;
  logic [PC_W-1:0] sel_target, pred_target, pred_pc;
  logic [1:0]      sel_type;
  logic            fire;

  fetch_lane_sel #(
    .FETCH_WIDTH(FETCH_WIDTH),
    .PC_W       (PC_W),
    .TK_W       (TK_W)
  ) u_lane_sel (
    .btb_hit   (btb_hit_i),
    .btb_type  (btb_type_i),
    .btb_target(btb_target_i),
    .pred      (pred_i),
    .any_taken (any_taken),
    .tk        (tk),
    .lane_mask (lane_mask_o),
    .sel_target(sel_target),
    .sel_type  (sel_type)
  );

  assign valid_o = (state == ST_RUN) & ~icache_miss_i;
  assign fire    = valid_o & ~stall_i & any_taken;
  assign pred_pc = any_taken ? pred_target : pc + STRIDE;

`ifdef FETCH_RAS_EN
  assign pred_target = (sel_type == BT_RET) ? ras_top_i : sel_target;
  assign ras_push_o  = fire & (sel_type == BT_CALL);
  assign ras_pop_o   = fire & (sel_type == BT_RET);
`else
  logic unused_ras;
  assign unused_ras  = ^{ras_top_i, sel_type, fire};
  assign pred_target = sel_target;
  assign ras_push_o  = 1'b0;
  assign ras_pop_o   = 1'b0;
`endif

  assign ras_push_addr_o = pc + PC_W'((int'(tk) + 1) * INST_BYTES);
  assign pc_o            = pc;
  assign miss_o          = (state == ST_MISS);
  assign miss_addr_o     = pc;

  always_comb begin
    next_pc    = pc;
    next_state = state;
    if (recover_valid_i) begin
      next_pc    = recover_pc_i;
      next_state = ST_RUN;
    end else if (exc_valid_i) begin
      next_pc    = exc_pc_i;
      next_state = ST_RUN;
    end else if (redir_ex_i) begin
      next_pc    = redir_ex_pc_i;
      next_state = ST_RUN;
    end else if (redir_id_i && !stall_i) begin
      next_pc    = redir_id_pc_i;
      next_state = ST_RUN;
    end else if (state == ST_MISS) begin
      // The refill pulse is honoured even under stall; the PC holds either way.
      if (refill_done_i) next_state = ST_RUN;
    end else if (stall_i) begin
      next_pc = pc;
    end else if (icache_miss_i) begin
      next_state = ST_MISS;
    end else begin
      next_pc = pred_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else begin
      pc    <= next_pc;
      state <= next_state;
    end
  end

endmodule

// File: doc/fetch_pc_ctrl.md
FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter FETCH_WIDTH, default 4, SHALL set the number of instruction lanes fetched per cycle.
REQ-002 Parameter INST_BYTES, default 8, SHALL set the byte stride between adjacent lanes.
REQ-003 Parameter PC_W, default 32, SHALL set the PC width.
REQ-004 Parameter RESET_PC, default 0, SHALL set the PC loaded on reset.
REQ-005 Ports SHALL be as follows, listed as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; asserted at 0.
- stall_i  in  1  downstream stall.
- recover_valid_i / recover_pc_i  in  1 / PC_W  commit-time recovery.
- exc_valid_i / exc_pc_i  in  1 / PC_W  exception redirect.
- redir_ex_i / redir_ex_pc_i  in  1 / PC_W  execute-stage mispredict.
- redir_id_i / redir_id_pc_i  in  1 / PC_W  decode-stage mispredict.
- btb_hit_i  in  FETCH_WIDTH  per-lane BTB hit.
- btb_type_i  in  2*FETCH_WIDTH  per-lane type: 00 ret, 01 call, 10 jump, 11 cond.
- btb_target_i  in  PC_W*FETCH_WIDTH  per-lane target.
- pred_i  in  FETCH_WIDTH  per-lane direction, 1 = taken.
- ras_top_i  in  PC_W  RAS top-of-stack.
- icache_miss_i  in  1  I-cache miss for the current PC.
- refill_done_i  in  1  one-cycle pulse: refill complete.
- pc_o  out  PC_W  current fetch PC.
- valid_o  out  1  fetch bundle valid this cycle.
- lane_mask_o  out  FETCH_WIDTH  valid lanes, up to and including the first taken lane.
- ras_push_o / ras_push_addr_o  out  1 / PC_W  push request and return address.
- ras_pop_o  out  1  pop request.
- miss_o / miss_addr_o  out  1 / PC_W  outstanding miss and its PC.

Function
REQ-006 Lane k SHALL be taken iff btb_hit_i[k] and (type != 11 or pred_i[k]); the lowest taken lane, tk, SHALL win.
REQ-007 The sequential next PC SHALL be PC + FETCH_WIDTH*INST_BYTES, truncated modulo 2^PC_W.
REQ-008 The predicted next PC SHALL be the lane-tk target (ret: REQ-020), or sequential if no lane is taken.
REQ-009 PC update priority SHALL be: recover > exception > redir_ex (applies even under stall) > redir_id (ignored under stall) > stall (hold) > miss handling > predicted.
REQ-010 lane_mask_o SHALL set bits 0..tk, or all bits when no lane is taken.
REQ-011 ras_push_o SHALL equal valid_o & ~stall_i & (lane tk is a call); ras_push_addr_o SHALL be PC+(tk+1)*INST_BYTES.
REQ-012 ras_pop_o SHALL equal valid_o & ~stall_i & (lane tk is a ret).
REQ-013 The FSM SHALL have two states: RUN and MISS.
REQ-014 RUN -> MISS SHALL occur when icache_miss_i=1 and no redirect is present; the PC SHALL hold.
REQ-015 In MISS, miss_o SHALL be 1 and miss_addr_o SHALL be the PC.
REQ-016 MISS -> RUN SHALL occur on refill_done_i, with the same PC re-fetched.
REQ-017 Any redirect in MISS SHALL load the new PC, return to RUN and drop the miss; a simultaneous refill_done_i SHALL be ignored.
REQ-018 valid_o SHALL equal (state==RUN) & ~icache_miss_i; push/pop outputs SHALL be 0 whenever valid_o=0.
REQ-019 All outputs except PC and state SHALL be combinational, with zero-cycle latency.

Configuration
REQ-020 With FETCH_RAS_EN defined, the ret-lane target SHALL be ras_top_i and ras_push_o/ras_pop_o SHALL be live; without it, the ret target SHALL be btb_target_i and ras_push_o/ras_pop_o SHALL be tied to 0.

Reset
REQ-021 Asserting reset (reset=0) SHALL asynchronously set PC=RESET_PC and state=RUN.
REQ-022 Reset asserted mid-MISS SHALL abandon the miss; miss_o SHALL be 0 while reset is held.
REQ-023 During reset, valid_o SHALL follow REQ-018 using icache_miss_i.

Structure
REQ-024 The shared package SHALL hold the branch-type encodings (RET/CALL/JUMP/COND) and the RUN/MISS state enum.
REQ-025 Sub-module fetch_lane_sel SHALL compute taken lanes, tk, lane_mask_o and the selected target; it SHALL be purely combinational and parametrised by FETCH_WIDTH.

Verification
REQ-026 Reset release with no hits -> pc_o = 0, 32, 64 on successive cycles; lane_mask_o = 1111.
REQ-027 PC=0x100, lane 2 call hit with target 0x400 -> next PC 0x400; ras_push_addr_o = 0x118; lane_mask_o = 0111.
REQ-028 Lane 1 cond hit with pred 0, lane 3 jump hit to 0x80 -> next PC 0x80; lane_mask_o = 1111.
REQ-029 icache_miss_i at PC 0x200, refill after 5 cycles -> miss_o=1 for 5 cycles, then pc_o = 0x200 with valid_o=1.
REQ-030 stall_i=1 with redir_id_i to 0x40 and redir_ex_i to 0x80 in the same cycle -> next PC 0x80; the ID redirect is dropped.
REQ-031 In MISS, redir_ex_i to 0x300 arrives together with refill_done_i -> state RUN, pc_o = 0x300, miss_o = 0.
